circ_smpl_queue: RTL and testbench

- Parametrised multi-channel circular sample queue for the audio filter path; successor to the fixed 1536x16 high-frequency queue.
- Stores the last DEPTH samples per channel.
- On each qualifying sample strobe, streams the most recent TAPS samples, oldest first, one per clk, to the downstream FIR MAC.
- Adds configurable width, depth, channel count and window length, decimated sequencing (low-frequency mode), fully synchronous control, and overrun detection.

---
 rtl/circ_q_pkg.sv | 19 +
 rtl/circ_dpram.sv | 47 ++++
 rtl/circ_smpl_queue.sv | 164 ++++++++++++++++
 tb/tb_circ_smpl_queue.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/circ_q_pkg.sv
// rtl/circ_q_pkg.sv - shared types and pointer helpers for the circular sample queue
// Purpose: sequencer state encoding and modulo pointer arithmetic that does not
//          rely on the queue depth being a power of two.
package circ_q_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // (a - b) mod m for a < m and b < m, done with compare/add only.
    function automatic int unsigned mod_sub(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned m);
        return (a >= b) ? (a - b) : (a + m - b);
    endfunction

endpackage

// File: rtl/circ_dpram.sv
// rtl/circ_dpram.sv - simple dual-port RAM with one registered read port
// Purpose: sample storage; one write port, one read port with 1-cycle latency.
// Ports:
//   clk      - clock
//   rst_n    - async active-low reset, clears only the read data register
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   re_i     - read enable; rdata_o holds when low
//   raddr_i  - read address
//   rdata_o  - registered read data
module circ_dpram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1536,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Data array deliberately has no reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/circ_smpl_queue.sv
// rtl/circ_smpl_queue.sv - multi-channel circular sample queue with windowed streaming
// Purpose: keeps the last DEPTH samples per channel and, on qualifying writes,
//          streams the most recent TAPS words oldest-first to the FIR MAC.
// Ports:
//   clk        - clock
//   rst_n      - async active-low reset
//   wrt_smpl   - single-cycle sample write strobe
//   new_smpl   - sample word, channel 0 in LSBs
//   smpl_out   - streamed sample word, holds while sequencing is low
//   sequencing - smpl_out valid
//   seq_first  - first word of a window
//   seq_last   - last word of a window
//   primed     - at least TAPS samples stored
//   overrun    - sticky, a write arrived while a window was being streamed
module circ_smpl_queue
    import circ_q_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 1536,
    parameter int TAPS   = 1021,
    parameter int DECIM  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wrt_smpl,
    input  logic [NUM_CH*DATA_W-1:0] new_smpl,
    output logic [NUM_CH*DATA_W-1:0] smpl_out,
    output logic                     sequencing,
    output logic                     seq_first,
    output logic                     seq_last,
    output logic                     primed,
    output logic                     overrun
);

    localparam int W     = NUM_CH * DATA_W;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int DCM_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] TAPS_C    = CNT_W'(TAPS);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
    localparam logic [DCM_W-1:0] DCM_LAST  = DCM_W'(DECIM - 1);

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   rd_left_q, rd_left_d;
    logic [DCM_W-1:0]   decim_q, decim_d;
    logic               overrun_q, overrun_d;
    logic               primed_q;
    logic               seq_q, first_q, last_q;
    logic               primed_wr, start, rd_en;
    logic [PTR_W-1:0]   win_start;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        cnt_d     = cnt_q;
        decim_d   = decim_q;
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        rd_left_d = rd_left_q;
        rd_en     = 1'b0;
        overrun_d = overrun_q;

        if (wrt_smpl) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (state_q != IDLE) begin
                overrun_d = 1'b1;
            end
        end

        // Primed-ness is judged on the post-write count, so the write that
        // fills the window already qualifies.
        primed_wr = wrt_smpl && (cnt_d >= TAPS_C);
        start     = primed_wr && (decim_q == '0) && (state_q == IDLE);
        if (primed_wr) begin
            decim_d = (decim_q == DCM_LAST) ? '0 : decim_q + 1'b1;
        end

        // Oldest sample of the window ending at the address being written now.
        win_start = PTR_W'(mod_sub(32'(wr_ptr_q), 32'(TAPS - 1), 32'(DEPTH)));

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    rd_ptr_d  = win_start;
                    rd_left_d = TAPS_C;
                end
            end
            RUN: begin
                rd_en     = 1'b1;
                rd_ptr_d  = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
                rd_left_d = rd_left_q - 1'b1;
                if (rd_left_q == ONE_C) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            rd_left_q <= '0;
            decim_q   <= '0;
            overrun_q <= 1'b0;
            primed_q  <= 1'b0;
            seq_q     <= 1'b0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            rd_left_q <= rd_left_d;
            decim_q   <= decim_d;
            overrun_q <= overrun_d;
            primed_q  <= (cnt_d >= TAPS_C);
            // Flags are aligned with the RAM's registered read data.
            seq_q     <= rd_en;
            first_q   <= rd_en && (rd_left_q == TAPS_C);
            last_q    <= rd_en && (rd_left_q == ONE_C);
        end
    end

    circ_dpram #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (wrt_smpl),
        .waddr_i (wr_ptr_q),
        .wdata_i (new_smpl),
        .re_i    (rd_en),
        .raddr_i (rd_ptr_q),
        .rdata_o (smpl_out)
    );

    assign sequencing = seq_q;
    assign seq_first  = first_q;
    assign seq_last   = last_q;
    assign primed     = primed_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_circ_smpl_queue.sv
// tb/tb_circ_smpl_queue.sv - directed self-checking bench for circ_smpl_queue
module tb_circ_smpl_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wrt = 1'b0;
    logic [31:0] data = '0;

    logic [31:0] out1, out2;
    logic        seq1, first1, last1, prim1, ovr1;
    logic        seq2, first2, last2, prim2, ovr2;

    logic        sel = 1'b0;
    logic [31:0] m_out;
    logic        m_seq, m_first, m_last, m_primed, m_ovr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    circ_smpl_queue #(.DATA_W(16), .NUM_CH(2), .DEPTH(8), .TAPS(4), .DECIM(1)) dut (
        .clk(clk), .rst_n(rst_n), .wrt_smpl(wrt), .new_smpl(data),
        .smpl_out(out1), .sequencing(seq1), .seq_first(first1), .seq_last(last1),
        .primed(prim1), .overrun(ovr1));

    circ_smpl_queue #(.DATA_W(16), .NUM_CH(2), .DEPTH(8), .TAPS(4), .DECIM(2)) dut_d2 (
        .clk(clk), .rst_n(rst_n), .wrt_smpl(wrt), .new_smpl(data),
        .smpl_out(out2), .sequencing(seq2), .seq_first(first2), .seq_last(last2),
        .primed(prim2), .overrun(ovr2));

    always_comb begin
        m_out    = sel ? out2   : out1;
        m_seq    = sel ? seq2   : seq1;
        m_first  = sel ? first2 : first1;
        m_last   = sel ? last2  : last1;
        m_primed = sel ? prim2  : prim1;
        m_ovr    = sel ? ovr2   : ovr1;
    end

    typedef struct {
        logic [15:0] d0;
        logic [15:0] d1;
        bit          exp_seq;
        int          base;
        bit          exp_primed;
    } vec_t;

    vec_t tv1 [10];
    vec_t tv2 [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Watches 9 falling edges after a write; window must start at exp_start.
    task automatic collect(input bit exp_seq, input int base, input int exp_start,
                           input bit exp_primed, input string nm);
        int n = 0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            wrt = 1'b0;
            if (m_seq) begin
                if (n == 0) chk({nm, " start"}, 32'(c), 32'(exp_start));
                chk({nm, " ch0"}, {16'd0, m_out[15:0]}, 32'(base + n));
                chk({nm, " ch1"}, {16'd0, m_out[31:16]}, 32'(base + 100 + n));
                chk({nm, " first"}, {31'd0, m_first}, {31'd0, n == 0});
                chk({nm, " last"}, {31'd0, m_last}, {31'd0, n == 3});
                n++;
            end
        end
        chk({nm, " count"}, 32'(n), exp_seq ? 32'd4 : 32'd0);
        chk({nm, " primed"}, {31'd0, m_primed}, {31'd0, exp_primed});
    endtask

    task automatic wr(input int v, input bit exp_seq, input int base,
                      input bit exp_primed, input string nm);
        @(negedge clk);
        wrt  = 1'b1;
        data = {16'(v + 100), 16'(v)};
        collect(exp_seq, base, 1, exp_primed, nm);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 10; i++) begin
            tv1[i] = '{d0: 16'(i + 1), d1: 16'(i + 101), exp_seq: (i >= 3),
                       base: (i >= 3) ? i - 2 : 0, exp_primed: (i >= 3)};
        end
        tv2[0] = '{16'd1, 16'd101, 1'b0, 0, 1'b0};
        tv2[1] = '{16'd2, 16'd102, 1'b0, 0, 1'b0};
        tv2[2] = '{16'd3, 16'd103, 1'b0, 0, 1'b0};
        tv2[3] = '{16'd4, 16'd104, 1'b1, 1, 1'b1};
        tv2[4] = '{16'd5, 16'd105, 1'b0, 0, 1'b1};
        tv2[5] = '{16'd6, 16'd106, 1'b1, 3, 1'b1};
        tv2[6] = '{16'd7, 16'd107, 1'b0, 0, 1'b1};
        tv2[7] = '{16'd8, 16'd108, 1'b1, 5, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst smpl_out", out1, 32'd0);
        chk("rst sequencing", {31'd0, seq1}, 32'd0);
        chk("rst first", {31'd0, first1}, 32'd0);
        chk("rst last", {31'd0, last1}, 32'd0);
        chk("rst primed", {31'd0, prim1}, 32'd0);
        chk("rst overrun", {31'd0, ovr1}, 32'd0);
        chk("rst d2 smpl_out", out2, 32'd0);
        rst_n = 1'b1;

        // Priming, basic window and wrap (writes 9,10 land at addresses 0,1)
        sel = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            wrt  = 1'b1;
            data = {tv1[i].d1, tv1[i].d0};
            collect(tv1[i].exp_seq, tv1[i].base, 1, tv1[i].exp_primed,
                    $sformatf("t1 w%0d", i + 1));
        end
        chk("t1 overrun", {31'd0, m_ovr}, 32'd0);

        // Overrun: write 5 one clock after the starting write 4
        do_reset();
        wr(1, 1'b0, 0, 1'b0, "ov w1");
        wr(2, 1'b0, 0, 1'b0, "ov w2");
        wr(3, 1'b0, 0, 1'b0, "ov w3");
        @(negedge clk);
        wrt  = 1'b1;
        data = {16'd104, 16'd4};
        @(negedge clk);
        data = {16'd105, 16'd5};
        collect(1'b1, 1, 0, 1'b1, "ov w4w5");
        chk("ov set", {31'd0, m_ovr}, 32'd1);
        wr(6, 1'b1, 3, 1'b1, "ov w6");
        chk("ov sticky", {31'd0, m_ovr}, 32'd1);

        // Decimated sequencing
        do_reset();
        sel = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            wrt  = 1'b1;
            data = {tv2[i].d1, tv2[i].d0};
            collect(tv2[i].exp_seq, tv2[i].base, 1, tv2[i].exp_primed,
                    $sformatf("d2 w%0d", i + 1));
        end
        sel = 1'b0;

        // Reset in the middle of a window
        do_reset();
        wr(1, 1'b0, 0, 1'b0, "mr w1");
        wr(2, 1'b0, 0, 1'b0, "mr w2");
        wr(3, 1'b0, 0, 1'b0, "mr w3");
        @(negedge clk);
        wrt  = 1'b1;
        data = {16'd104, 16'd4};
        @(negedge clk);
        wrt = 1'b0;
        @(negedge clk);
        chk("mr seq 1st", {31'd0, m_seq}, 32'd1);
        @(negedge clk);
        chk("mr seq 2nd", {31'd0, m_seq}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mr seq drop", {31'd0, m_seq}, 32'd0);
        chk("mr out clr", m_out, 32'd0);
        chk("mr primed clr", {31'd0, m_primed}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wr(11, 1'b0, 0, 1'b0, "mr post1");
        wr(12, 1'b0, 0, 1'b0, "mr post2");
        wr(13, 1'b0, 0, 1'b0, "mr post3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
